hub75_rx: RTL and testbench

Receive-side endpoint of the HUB75 LED-panel bus. The block samples an incoming HUB75 stream on the 100 MHz system clock: shift clock, latch, row address A/B/C and the six colour lines. It deserializes one row-pair per latch pulse and hands it to a frame store over a valid/ready handshake. It sits opposite the panel driver and is used to capture and check what the driver emits, and to emulate a panel in loopback.

---
 rtl/hub75_pkg.sv | 21 ++
 rtl/hub75_sync_edge.sv | 65 ++++++
 rtl/hub75_rx.sv | 141 ++++++++++++++
 tb/tb_hub75_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 receive endpoint: pixel lane order,
// column default and the synchronizer data-group width.
package hub75_pkg;

  localparam int HUB75_COLS_DEF = 32;

  // Bit position of each colour line inside one 6-bit column.
  localparam int IDX_R1 = 0;
  localparam int IDX_G1 = 1;
  localparam int IDX_B1 = 2;
  localparam int IDX_R2 = 3;
  localparam int IDX_G2 = 4;
  localparam int IDX_B2 = 5;

  localparam int PIX_W   = 6;
  localparam int ADDR_W  = 3;
  localparam int SYNC_DW = PIX_W + ADDR_W;

  typedef logic [ADDR_W-1:0] row_addr_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// Input capture for the HUB75 bus: colour, address, shift clock and latch cross as one
// group (2 flops with HUB75_RX_SYNC_EN defined, 1 flop otherwise), then prev-based edge detect.
module hub75_sync_edge #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i,
  input  logic          hub_clk_i,
  input  logic          latch_i,
  output logic [DW-1:0] data_o,
  output logic          clk_rise_o,
  output logic          lat_rise_o
);

`ifdef HUB75_RX_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int W = DW + 2;

  logic [DEPTH-1:0][W-1:0] stage_q, stage_d;
  logic [DEPTH-1:0]        fill_q, fill_d;
  logic [1:0]              prev_q, prev_d;
  logic                    armed_q, armed_d;
  logic [W-1:0]            tail;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    stage_d    = stage_q;
    fill_d     = fill_q;
    stage_d[0] = {latch_i, hub_clk_i, data_i};
    fill_d[0]  = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
      fill_d[i]  = fill_q[i-1];
    end
    tail    = stage_q[DEPTH-1];
    prev_d  = tail[W-1:DW];
    // prev only holds a real sample once the pipeline has refilled after reset,
    // so a line already high at reset release never looks like a rising edge.
    armed_d = fill_q[DEPTH-1];
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      fill_q  <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign data_o     = tail[DW-1:0];
  assign clk_rise_o = armed_q & tail[DW]   & ~prev_q[0];
  assign lat_rise_o = armed_q & tail[DW+1] & ~prev_q[1];

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receive endpoint: deserializes one row-pair per latch and offers it on a
// valid/ready port. Input synchronizer depth selected by HUB75_RX_SYNC_EN.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS  = HUB75_COLS_DEF,
  parameter int CNT_W = $clog2(COLS + 1)
) (
  input  logic                  Clkin,
  input  logic                  Rst,
  input  logic                  HubClk,
  input  logic                  Latin,
  input  logic                  Ain,
  input  logic                  Bin,
  input  logic                  Cin,
  input  logic                  R1in,
  input  logic                  G1in,
  input  logic                  B1in,
  input  logic                  R2in,
  input  logic                  G2in,
  input  logic                  B2in,
  output logic [6*COLS-1:0]     RowData,
  output logic [2:0]            RowAddr,
  output logic                  RowValid,
  input  logic                  RowReady,
  output logic [CNT_W-1:0]      BitCount,
  output logic                  ShortRow,
  output logic                  Overrun,
  input  logic                  ClrFlags
);

  localparam int               ROW_W   = PIX_W * COLS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ROW = CNT_W'(COLS);

  logic [SYNC_DW-1:0] raw_data, sync_data;
  logic               clk_rise, lat_rise;
  logic               out_free;

  logic [ROW_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_data_q, row_data_d;
  row_addr_t        row_addr_q, row_addr_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             row_valid_q, row_valid_d;
  logic             short_q, short_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    raw_data                  = '0;
    raw_data[IDX_R1]          = R1in;
    raw_data[IDX_G1]          = G1in;
    raw_data[IDX_B1]          = B1in;
    raw_data[IDX_R2]          = R2in;
    raw_data[IDX_G2]          = G2in;
    raw_data[IDX_B2]          = B2in;
    raw_data[PIX_W +: ADDR_W] = {Cin, Bin, Ain};
  end

  hub75_sync_edge #(
    .DW (SYNC_DW)
  ) u_sync_edge (
    .clk        (Clkin),
    .rst        (Rst),
    .data_i     (raw_data),
    .hub_clk_i  (HubClk),
    .latch_i    (Latin),
    .data_o     (sync_data),
    .clk_rise_o (clk_rise),
    .lat_rise_o (lat_rise)
  );

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    row_data_d  = row_data_q;
    row_addr_d  = row_addr_q;
    bit_count_d = bit_count_q;
    row_valid_d = row_valid_q && !RowReady;
    short_d     = short_q;
    overrun_d   = overrun_q;
    out_free    = !row_valid_q || RowReady;

    // Shift is resolved first so a latch in the same sample captures the new bit.
    if (clk_rise) begin
      shift_d            = shift_q << PIX_W;
      shift_d[PIX_W-1:0] = sync_data[PIX_W-1:0];
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    if (lat_rise) begin
      if (out_free) begin
        row_data_d  = shift_d;
        row_addr_d  = sync_data[PIX_W +: ADDR_W];
        bit_count_d = cnt_d;
        row_valid_d = 1'b1;
        if (cnt_d != CNT_ROW) short_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      cnt_d = '0;
    end

    if (ClrFlags) begin
      short_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // NOTE: the shift chain and row register are reset too, so a row cut short by reset
  // can never leak stale columns into a later capture.
  always_ff @(posedge Clkin) begin
    if (Rst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      row_data_q  <= '0;
      row_addr_q  <= '0;
      bit_count_q <= '0;
      row_valid_q <= 1'b0;
      short_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      row_data_q  <= row_data_d;
      row_addr_q  <= row_addr_d;
      bit_count_q <= bit_count_d;
      row_valid_q <= row_valid_d;
      short_q     <= short_d;
      overrun_q   <= overrun_d;
    end
  end

  assign RowData  = row_data_q;
  assign RowAddr  = row_addr_q;
  assign RowValid = row_valid_q;
  assign BitCount = bit_count_q;
  assign ShortRow = short_q;
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: full, short, overrun, back-to-back, simultaneous-edge
// and mid-row-reset cases with hand-derived expected rows.
module tb_hub75_rx;

  localparam int COLS  = 32;
  localparam int CNT_W = $clog2(COLS + 1);
`ifdef HUB75_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst, hub_clk, latin, a_in, b_in, c_in;
  logic              r1, g1, b1, r2, g2, b2;
  logic              row_ready, clr_flags;
  logic [6*COLS-1:0] row_data;
  logic [2:0]        row_addr;
  logic              row_valid;
  logic [CNT_W-1:0]  bit_count;
  logic              short_row, overrun;

  logic [6*COLS-1:0] exp_row;
  int                n_cmp = 0;
  int                n_bad = 0;
  int                lat;

  always #5 clk = ~clk;

  hub75_rx #(.COLS(COLS)) dut (
    .Clkin    (clk),
    .Rst      (rst),
    .HubClk   (hub_clk),
    .Latin    (latin),
    .Ain      (a_in),
    .Bin      (b_in),
    .Cin      (c_in),
    .R1in     (r1),
    .G1in     (g1),
    .B1in     (b1),
    .R2in     (r2),
    .G2in     (g2),
    .B2in     (b2),
    .RowData  (row_data),
    .RowAddr  (row_addr),
    .RowValid (row_valid),
    .RowReady (row_ready),
    .BitCount (bit_count),
    .ShortRow (short_row),
    .Overrun  (overrun),
    .ClrFlags (clr_flags)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic [5:0] pix);
    {b2, g2, r2, b1, g1, r1} = pix;
    hub_clk = 1'b0;
    cyc(3);
    hub_clk = 1'b1;
    cyc(3);
  endtask

  task automatic pulse_latch(input logic [2:0] addr, input bit measure, output int n);
    {c_in, b_in, a_in} = addr;
    hub_clk = 1'b0;
    cyc(2);
    latin = 1'b1;
    n = 0;
    if (measure) begin
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk);
        #1;
        if (row_valid) begin
          n = i;
          break;
        end
      end
    end
    cyc(3);
    latin = 1'b0;
    cyc(3);
  endtask

  task automatic accept(input string tag);
    row_ready = 1'b1;
    cyc(1);
    row_ready = 1'b0;
    check(tag, row_valid, 1'b0);
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hub_clk = 1'b1; latin = 1'b1;
    {c_in, b_in, a_in} = 3'd0;
    {b2, g2, r2, b1, g1, r1} = 6'd0;
    row_ready = 1'b0; clr_flags = 1'b0;
    cyc(3);
    check("rst_valid", row_valid, 1'b0);
    check("rst_data", row_data, '0);
    check("rst_count", bit_count, '0);
    check("rst_short", short_row, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Shift clock and latch already high at release must not register as edges.
    rst = 1'b0;
    cyc(6);
    check("no_edge_valid", row_valid, 1'b0);
    hub_clk = 1'b0; latin = 1'b0;
    cyc(4);

    // Full row: column k = k, address 5.
    for (int j = 0; j < COLS; j++) shift_bit(6'(COLS - 1 - j));
    for (int k = 0; k < COLS; k++) exp_row[6*k +: 6] = 6'(k);
    pulse_latch(3'd5, 1'b1, lat);
    check("full_latency", lat, LAT);
    check("full_data", row_data, exp_row);
    check("full_addr", row_addr, 3'd5);
    check("full_count", bit_count, 32);
    check("full_short", short_row, 1'b0);
    accept("full_accept");

    // Short row: 20 new bits; the untouched chain shifts the old row up by 20.
    for (int j = 0; j < 20; j++) shift_bit(6'(j + 1));
    for (int k = 0; k < COLS; k++) exp_row[6*k +: 6] = (k < 20) ? 6'(20 - k) : 6'(k - 20);
    pulse_latch(3'd2, 1'b0, lat);
    check("short_count", bit_count, 20);
    check("short_flag", short_row, 1'b1);
    check("short_addr", row_addr, 3'd2);
    check("short_data", row_data, exp_row);
    clear_flags();
    check("short_clear", short_row, 1'b0);
    accept("short_accept");

    // Overrun: row A held while row B arrives with no consumer.
    for (int j = 0; j < COLS; j++) shift_bit(6'(32 + j));
    for (int k = 0; k < COLS; k++) exp_row[6*k +: 6] = 6'(63 - k);
    pulse_latch(3'd1, 1'b0, lat);
    for (int j = 0; j < COLS; j++) shift_bit(6'h15);
    pulse_latch(3'd6, 1'b0, lat);
    check("ovr_valid", row_valid, 1'b1);
    check("ovr_data", row_data, exp_row);
    check("ovr_addr", row_addr, 3'd1);
    check("ovr_flag", overrun, 1'b1);
    accept("ovr_accept");
    clear_flags();
    check("ovr_clear", overrun, 1'b0);

    // Back-to-back: ready coincides with the detection cycle of the second latch.
    for (int j = 0; j < COLS; j++) shift_bit(6'h0F);
    pulse_latch(3'd3, 1'b0, lat);
    for (int j = 0; j < COLS; j++) shift_bit(6'(j));
    for (int k = 0; k < COLS; k++) exp_row[6*k +: 6] = 6'(31 - k);
    {c_in, b_in, a_in} = 3'd4;
    hub_clk = 1'b0;
    cyc(2);
    latin = 1'b1;
    cyc(LAT - 1);
    row_ready = 1'b1;
    cyc(1);
    row_ready = 1'b0;
    check("b2b_valid", row_valid, 1'b1);
    check("b2b_data", row_data, exp_row);
    check("b2b_addr", row_addr, 3'd4);
    check("b2b_overrun", overrun, 1'b0);
    cyc(2);
    latin = 1'b0;
    cyc(3);
    accept("b2b_accept");

    // Simultaneous shift and latch on the 32nd bit.
    for (int j = 0; j < COLS - 1; j++) shift_bit(6'h01);
    {b2, g2, r2, b1, g1, r1} = 6'h2C;
    {c_in, b_in, a_in} = 3'd7;
    hub_clk = 1'b0;
    cyc(3);
    hub_clk = 1'b1;
    latin = 1'b1;
    cyc(3);
    hub_clk = 1'b0;
    latin = 1'b0;
    cyc(3);
    for (int k = 0; k < COLS; k++) exp_row[6*k +: 6] = (k == 0) ? 6'h2C : 6'h01;
    check("simul_count", bit_count, 32);
    check("simul_data", row_data, exp_row);
    check("simul_addr", row_addr, 3'd7);
    check("simul_short", short_row, 1'b0);
    accept("simul_accept");

    // Reset mid-row: the partial row and its count must vanish.
    for (int j = 0; j < 10; j++) shift_bit(6'h3F);
    hub_clk = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    check("mid_rst_count", bit_count, '0);
    for (int j = 0; j < COLS; j++) shift_bit(6'(j) ^ 6'h2A);
    for (int k = 0; k < COLS; k++) exp_row[6*k +: 6] = 6'(31 - k) ^ 6'h2A;
    pulse_latch(3'd0, 1'b1, lat);
    check("mid_rst_latency", lat, LAT);
    check("mid_rst_bits", bit_count, 32);
    check("mid_rst_data", row_data, exp_row);
    check("mid_rst_short", short_row, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
